// File: rtl/noc_pkg.sv
// Shared deflection-NoC packet helpers: field offsets, packet width and
// local/misrouted classification of an ejected packet.
package noc_pkg;

  typedef enum logic {
    PKT_LOCAL     = 1'b0,
    PKT_MISROUTED = 1'b1
  } pkt_class_e;

  // Wide enough for any address width used on the network.
  localparam int ADDR_MAX_W = 16;

  // Packet layout, MSB first: {v, defl, addr[a_w-1:0], data[d_w-1:0]}.
  function automatic int pkt_w(input int a_w, input int d_w);
    return a_w + d_w + 2;
  endfunction

  function automatic int v_bit(input int a_w, input int d_w);
    return a_w + d_w + 1;
  endfunction

  function automatic int defl_bit(input int a_w, input int d_w);
    return a_w + d_w;
  endfunction

  function automatic int addr_lsb(input int d_w);
    return d_w;
  endfunction

  function automatic pkt_class_e classify(input logic defl,
                                          input logic [ADDR_MAX_W-1:0] addr,
                                          input logic [ADDR_MAX_W-1:0] posx);
    return (!defl && addr == posx) ? PKT_LOCAL : PKT_MISROUTED;
  endfunction

endpackage

// File: rtl/nic_fifo.sv
// Synchronous strict FIFO holding misrouted packets awaiting reinjection.
// The caller guarantees push is legal (not full, or full with a pop).
module nic_fifo #(
  parameter int W     = 35,
  parameter int DEPTH = 2,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  head,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // NOTE: storage is not reset; clearing the pointers and count makes every
  // entry unreachable, which is all a reset has to guarantee.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/client_nic.sv
// Client-side NIC: delivers local ejected packets, buffers and reinjects
// misrouted ones ahead of new client traffic. Optional CLIENT_NIC_THROTTLE_EN
// restricts reinjection to every other cycle.
module client_nic
  import noc_pkg::*;
#(
  parameter int N     = 4,
  parameter int D_W   = 32,
  parameter int A_W   = $clog2(N) + 1,
  parameter int POSX  = 0,
  parameter int DEPTH = 2,
  localparam int PW   = pkt_w(A_W, D_W),
  localparam int OW   = $clog2(DEPTH) + 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [PW-1:0]  o_rtr,
  output logic [PW-1:0]  i_rtr,
  input  logic           src_v,
  input  logic [A_W-1:0] src_addr,
  input  logic [D_W-1:0] src_d,
  output logic           src_ready,
  output logic           dst_v,
  output logic [D_W-1:0] dst_d,
  output logic [OW-1:0]  occ,
  output logic           overflow
);

  localparam int V_BIT    = v_bit(A_W, D_W);
  localparam int DEFL_BIT = defl_bit(A_W, D_W);
  localparam int ADDR_LSB = addr_lsb(D_W);

  logic           in_v;
  logic           in_defl;
  logic [A_W-1:0] in_addr;
  logic [D_W-1:0] in_data;
  pkt_class_e     in_class;

  assign in_v     = o_rtr[V_BIT];
  assign in_defl  = o_rtr[DEFL_BIT];
  assign in_addr  = o_rtr[ADDR_LSB +: A_W];
  assign in_data  = o_rtr[D_W-1:0];
  assign in_class = classify(in_defl, ADDR_MAX_W'(in_addr), ADDR_MAX_W'(POSX));

  logic deliver, push_req, push, pop, drop, reinj_ok;
  logic fifo_full, fifo_empty;
  logic [A_W+D_W-1:0] head;

  assign deliver  = in_v && (in_class == PKT_LOCAL);
  assign push_req = in_v && (in_class == PKT_MISROUTED);
  assign pop      = !fifo_empty && reinj_ok;
  // A full FIFO still accepts a push when its head leaves in the same cycle.
  assign push     = push_req && (!fifo_full || pop);
  assign drop     = push_req && fifo_full && !pop;

`ifdef CLIENT_NIC_THROTTLE_EN
  logic phase;

  always_ff @(posedge clk) begin
    if (rst) phase <= 1'b0;
    else     phase <= ~phase;
  end

  assign reinj_ok = phase;
`else
  assign reinj_ok = 1'b1;
`endif

  nic_fifo #(
    .W     (A_W + D_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata ({in_addr, in_data}),
    .head  (head),
    .count (occ),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // New traffic waits while anything is buffered or arriving for the buffer.
  assign src_ready = (occ == '0) && !push_req;

  logic [PW-1:0] inj_next;

  // NOTE: defaulting every always_comb output first rules out latches.
  always_comb begin
    inj_next = '0;
    if (pop)                       inj_next = {1'b1, 1'b0, head};
    else if (src_v && src_ready)   inj_next = {1'b1, 1'b0, src_addr, src_d};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      i_rtr    <= '0;
      dst_v    <= 1'b0;
      dst_d    <= '0;
      overflow <= 1'b0;
    end else begin
      i_rtr <= inj_next;
      dst_v <= deliver;
      if (deliver) dst_d <= in_data;
      if (drop)    overflow <= 1'b1;
    end
  end

endmodule

// File: doc/client_nic.md
# client_nic

Client-side network interface for the deflection NoC, sitting between a traffic client and its router port. It classifies every packet the router ejects: locally addressed packets are delivered to the client, and deflected or misrouted packets are buffered and reinjected. Reinjection takes priority over new traffic, which the interface merges onto the router injection port through a ready/valid handshake.

## Interface
Packet format: {v, defl, addr[A_W-1:0], data[D_W-1:0]}, width PW = A_W+D_W+2.

Parameters:
- N, 4, total clients.
- D_W, 32, data width.
- A_W, $clog2(N)+1, address width.
- POSX, 0, this client's address.
- DEPTH, 2, reinjection FIFO depth (power of 2, ≥2).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- o_rtr  in  PW  packet ejected by router (valid = o_rtr[PW-1]).
- i_rtr  out  PW  packet injected to router, registered.
- src_v  in  1  client has a new packet.
- src_addr  in  A_W  destination of the new packet.
- src_d  in  D_W  payload of the new packet.
- src_ready  out  1  new packet accepted this cycle (combinational).
- dst_v  out  1  delivery strobe, registered.
- dst_d  out  D_W  delivered payload, registered.
- occ  out  $clog2(DEPTH)+1  FIFO occupancy.
- overflow  out  1  sticky drop flag.

## Operation
- Classification of o_rtr, when its valid bit is 1:
  - local: defl==0 and addr==POSX. The packet is delivered (dst_v, dst_d).
  - misrouted: defl==1 or addr!=POSX. The packet is pushed to the FIFO.
- The router cannot be backpressured, so delivery has no ready signal.
- Push when the FIFO is full:
  - With a pop in the same cycle, the push succeeds.
  - Otherwise the packet is dropped and overflow is set to 1, where it stays until rst.
- Injection, decided each cycle in priority order:
  1. FIFO nonempty and reinjection permitted: pop the head. Next-cycle i_rtr = {1,0,head.addr,head.data}.
  2. src_ready & src_v: next-cycle i_rtr = {1,0,src_addr,src_d}.
  3. Otherwise i_rtr = 0.
- src_ready = (occ==0) & ~push_this_cycle. New traffic is never injected while a reinjection is pending, even when throttled.
- The defl bit is always 0 on i_rtr.
- Self-addressed src packets pass through unmodified.
- The FIFO is strict FIFO. There is no bypass: a push in cycle t is poppable at t+1 at the earliest.
- Simultaneous push and pop leaves occ unchanged.

## Timing
- Reset values: i_rtr=0, dst_v=0, dst_d=0, occ=0, overflow=0, FIFO pointers=0, throttle phase=0. src_ready=1 after reset.
- rst applied mid-operation discards all FIFO contents within one cycle.
- Latencies:
  - o_rtr local → dst_v: 1 cycle.
  - src accept → i_rtr: 1 cycle.
  - o_rtr misrouted at t → i_rtr at t+2 at the earliest.
- Pointers wrap modulo DEPTH. occ ranges 0..DEPTH.

## Configuration
- Macro CLIENT_NIC_THROTTLE_EN.
- When defined:
  - A 1-bit phase register resets to 0 and toggles every cycle.
  - Reinjection is permitted only when phase==1.
- When undefined: reinjection is permitted every cycle.
- src_ready is unchanged in either mode.

## Structure
- Shared package noc_pkg holds:
  - packet field offsets (V_BIT, DEFL_BIT, ADDR_LSB);
  - the PW width expression;
  - a function that classifies a packet as local or misrouted given POSX.
- Command and pattern defines remain in commands.h.
- One sub-module, nic_fifo: synchronous FIFO with push, pop, head, count and full/empty outputs. The drop/overflow logic lives in client_nic.

## Test plan
N=4, POSX=2, A_W=3, D_W=32, DEPTH=2.
1. Reset: assert rst for 2 cycles → i_rtr=0, dst_v=0, occ=0, overflow=0, src_ready=1.
2. Local delivery: o_rtr={1,0,2,0xA5} at t → dst_v=1, dst_d=0xA5 at t+1; occ stays 0; i_rtr=0.
3. Deflection, macro off: o_rtr={1,1,1,0x11} at t with src_v=1, src_addr=3 → src_ready=0 at t and t+1; i_rtr={1,0,1,0x11} at t+2; src packet appears at t+3.
4. Ordering: misrouted A (0x1) at t and B (0x2) at t+1 → i_rtr carries A at t+2 and B at t+3; occ never exceeds 1.
5. Overflow, macro on: misrouted packets on 6 consecutive cycles →
   - overflow=1 by the cycle after the 6th push, and it stays 1;
   - reinjected packets appear only in odd-phase cycles, in arrival order;
   - dropped packets never appear on i_rtr.
6. Reset mid-operation: FIFO holding 2 entries, pulse rst → occ=0 and i_rtr=0 the next cycle; neither packet is ever reinjected.
